// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared constants for the 8-bit ALU command sequencer:
//   - ALU opcode constants (0..7 arithmetic, 8..F logical)
//   - FSM state encoding (IDLE / ISSUE / RESP)
//   - is_div_zero(): flags divide/modulo with a zero divisor
// -----------------------------------------------------------------------------
package alu_seq_pkg;

   localparam logic [3:0] OP_INC  = 4'h0;
   localparam logic [3:0] OP_DEC  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_RSUB = 4'h4;
   localparam logic [3:0] OP_MUL  = 4'h5;
   localparam logic [3:0] OP_DIV  = 4'h6;
   localparam logic [3:0] OP_MOD  = 4'h7;
   localparam logic [3:0] OP_AND  = 4'h8;
   localparam logic [3:0] OP_OR   = 4'h9;
   localparam logic [3:0] OP_NOTA = 4'hA;
   localparam logic [3:0] OP_NOTB = 4'hB;
   localparam logic [3:0] OP_NAND = 4'hC;
   localparam logic [3:0] OP_NOR  = 4'hD;
   localparam logic [3:0] OP_XOR  = 4'hE;
   localparam logic [3:0] OP_XNOR = 4'hF;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;

   // The downstream ALU has no zero-divisor handling, so these commands
   // must never reach it.
   function automatic logic is_div_zero(input logic [3:0] op, input logic [7:0] b);
      return ((op == OP_DIV) || (op == OP_MOD)) && (b == 8'h00);
   endfunction

endpackage

// File: rtl/alu_8_bit_sequencer.sv
// -----------------------------------------------------------------------------
// alu_8_bit_sequencer
// Registered command front-end for an 8-bit combinational ALU that sits
// beside this block in the parent.
//
// Optional feature macro: ALU_SEQ_ACCUM_EN
//   defined   : adds Cmd_Use_Acc_In and an 8-bit accumulator that can replace
//               operand A; it loads every captured result.
//   undefined : operand A always comes from Cmd_A_In.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Valid never depends on ready; once Rsp_Valid_Out is high the
// Rsp_* payload stays stable until the transfer edge.
//
// Ports:
//   Clock_In, Reset_In (async, active high)
//   Cmd_Valid_In / Cmd_Ready_Out / Cmd_Op_In / Cmd_A_In / Cmd_B_In : command
//   ALU_Enable_Out / ALU_Op_Out / ALU_A_Out / ALU_B_Out            : to ALU
//   ALU_Result_In / ALU_Carry_In                                   : from ALU
//   Rsp_Valid_Out / Rsp_Ready_In / Rsp_Result_Out / Rsp_Carry_Out /
//   Rsp_Zero_Out / Rsp_Div_Zero_Out                                : response
//   Busy_Out        : state != IDLE
//   Op_Count_Out    : completed responses, wraps
//   Dbg_State_Out   : current FSM state (alu_seq_pkg encoding)
// -----------------------------------------------------------------------------
module alu_8_bit_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned COUNT_WIDTH     = 16,
   parameter logic [7:0]  DIV_ZERO_RESULT = 8'hFF
) (
   input  logic                   Clock_In,
   input  logic                   Reset_In,
   input  logic                   Cmd_Valid_In,
   output logic                   Cmd_Ready_Out,
   input  logic [3:0]             Cmd_Op_In,
   input  logic [7:0]             Cmd_A_In,
   input  logic [7:0]             Cmd_B_In,
`ifdef ALU_SEQ_ACCUM_EN
   input  logic                   Cmd_Use_Acc_In,
`endif
   output logic                   ALU_Enable_Out,
   output logic [3:0]             ALU_Op_Out,
   output logic [7:0]             ALU_A_Out,
   output logic [7:0]             ALU_B_Out,
   input  logic [7:0]             ALU_Result_In,
   input  logic                   ALU_Carry_In,
   output logic                   Rsp_Valid_Out,
   input  logic                   Rsp_Ready_In,
   output logic [7:0]             Rsp_Result_Out,
   output logic                   Rsp_Carry_Out,
   output logic                   Rsp_Zero_Out,
   output logic                   Rsp_Div_Zero_Out,
   output logic                   Busy_Out,
   output logic [COUNT_WIDTH-1:0] Op_Count_Out,
   output logic [1:0]             Dbg_State_Out
);

   logic [1:0] state;
   logic       issue_div_zero;   // latched at acceptance, gates the ALU enable
   logic [7:0] a_sel;
   logic [7:0] cap_result;
   logic       cap_carry;

`ifdef ALU_SEQ_ACCUM_EN
   logic [7:0] acc;
   always_comb begin
      a_sel = Cmd_Use_Acc_In ? acc : Cmd_A_In;
   end
`else
   always_comb begin
      a_sel = Cmd_A_In;
   end
`endif

   // A zero divisor never enables the ALU, so its outputs are floating; the
   // substitute result is taken instead of whatever is on ALU_Result_In.
   always_comb begin
      cap_result = issue_div_zero ? DIV_ZERO_RESULT : ALU_Result_In;
      cap_carry  = issue_div_zero ? 1'b0 : ALU_Carry_In;
   end

   // Decoded straight from the async-reset state register so that enable and
   // valid fall the instant reset asserts.
   always_comb begin
      Cmd_Ready_Out  = (state == IDLE);
      Busy_Out       = (state != IDLE);
      Rsp_Valid_Out  = (state == RESP);
      ALU_Enable_Out = (state == ISSUE) && !issue_div_zero;
      Dbg_State_Out  = state;
   end

   always_ff @(posedge Clock_In or posedge Reset_In) begin
      if (Reset_In) begin
         state            <= IDLE;
         issue_div_zero   <= 1'b0;
         ALU_Op_Out       <= 4'h0;
         ALU_A_Out        <= 8'h00;
         ALU_B_Out        <= 8'h00;
         Rsp_Result_Out   <= 8'h00;
         Rsp_Carry_Out    <= 1'b0;
         Rsp_Zero_Out     <= 1'b0;
         Rsp_Div_Zero_Out <= 1'b0;
         Op_Count_Out     <= '0;
`ifdef ALU_SEQ_ACCUM_EN
         acc              <= 8'h00;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (Cmd_Valid_In) begin
                  ALU_Op_Out     <= Cmd_Op_In;
                  ALU_A_Out      <= a_sel;
                  ALU_B_Out      <= Cmd_B_In;
                  issue_div_zero <= is_div_zero(Cmd_Op_In, Cmd_B_In);
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               Rsp_Result_Out   <= cap_result;
               Rsp_Carry_Out    <= cap_carry;
               Rsp_Zero_Out     <= (cap_result == 8'h00);
               Rsp_Div_Zero_Out <= issue_div_zero;
`ifdef ALU_SEQ_ACCUM_EN
               acc              <= cap_result;
`endif
               state            <= RESP;
            end
            RESP: begin
               if (Rsp_Ready_In) begin
                  Op_Count_Out <= Op_Count_Out + COUNT_WIDTH'(1);
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_8_bit_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_8_bit_sequencer
// Bench for alu_8_bit_sequencer. Provides a behavioural ALU beside the DUT
// (driving random junk whenever the enable is low) and a transaction-level
// reference model checked every cycle, plus literal expectations.
// -----------------------------------------------------------------------------
module tb_alu_8_bit_sequencer;

   // ---------------- clock / reset ----------------
   logic        Clock_In = 1'b0;
   logic        Reset_In;
   always #5 Clock_In = ~Clock_In;

   logic        Cmd_Valid_In, Cmd_Ready_Out;
   logic [3:0]  Cmd_Op_In;
   logic [7:0]  Cmd_A_In, Cmd_B_In;
   logic        Cmd_Use_Acc_In;
   logic        ALU_Enable_Out;
   logic [3:0]  ALU_Op_Out;
   logic [7:0]  ALU_A_Out, ALU_B_Out, ALU_Result_In;
   logic        ALU_Carry_In;
   logic        Rsp_Valid_Out, Rsp_Ready_In;
   logic [7:0]  Rsp_Result_Out;
   logic        Rsp_Carry_Out, Rsp_Zero_Out, Rsp_Div_Zero_Out, Busy_Out;
   logic [15:0] Op_Count_Out;
   logic [1:0]  Dbg_State_Out;

   alu_8_bit_sequencer dut (
      .Clock_In(Clock_In), .Reset_In(Reset_In),
      .Cmd_Valid_In(Cmd_Valid_In), .Cmd_Ready_Out(Cmd_Ready_Out),
      .Cmd_Op_In(Cmd_Op_In), .Cmd_A_In(Cmd_A_In), .Cmd_B_In(Cmd_B_In),
`ifdef ALU_SEQ_ACCUM_EN
      .Cmd_Use_Acc_In(Cmd_Use_Acc_In),
`endif
      .ALU_Enable_Out(ALU_Enable_Out), .ALU_Op_Out(ALU_Op_Out),
      .ALU_A_Out(ALU_A_Out), .ALU_B_Out(ALU_B_Out),
      .ALU_Result_In(ALU_Result_In), .ALU_Carry_In(ALU_Carry_In),
      .Rsp_Valid_Out(Rsp_Valid_Out), .Rsp_Ready_In(Rsp_Ready_In),
      .Rsp_Result_Out(Rsp_Result_Out), .Rsp_Carry_Out(Rsp_Carry_Out),
      .Rsp_Zero_Out(Rsp_Zero_Out), .Rsp_Div_Zero_Out(Rsp_Div_Zero_Out),
      .Busy_Out(Busy_Out), .Op_Count_Out(Op_Count_Out),
      .Dbg_State_Out(Dbg_State_Out)
   );

   // ---------------- behavioural ALU ----------------
   function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
      logic [15:0] p;
      p = {8'h00, a} * {8'h00, b};
      case (op)
         4'h0: return {1'b0, a} + 9'd1;
         4'h1: return {1'b0, a} - 9'd1;
         4'h2: return {1'b0, a} + {1'b0, b};
         4'h3: return {1'b0, a} - {1'b0, b};
         4'h4: return {1'b0, b} - {1'b0, a};
         4'h5: return p[8:0];
         4'h6: return (b == 8'h00) ? 9'h000 : {1'b0, a / b};
         4'h7: return (b == 8'h00) ? 9'h000 : {1'b0, a % b};
         4'h8: return {1'b0, a & b};
         4'h9: return {1'b0, a | b};
         4'hA: return {1'b0, ~a};
         4'hB: return {1'b0, ~b};
         4'hC: return {1'b0, ~(a & b)};
         4'hD: return {1'b0, ~(a | b)};
         4'hE: return {1'b0, a ^ b};
         default: return {1'b0, ~(a ^ b)};
      endcase
   endfunction

   logic [8:0] alu_full, junk;
   always @(negedge Clock_In) junk <= 9'($urandom);
   assign alu_full      = alu_fn(ALU_Op_Out, ALU_A_Out, ALU_B_Out);
   assign ALU_Result_In = ALU_Enable_Out ? alu_full[7:0] : junk[7:0];
   assign ALU_Carry_In  = ALU_Enable_Out ? alu_full[8]   : junk[8];

   // ---------------- scoreboard ----------------
   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
   endtask

   task automatic timeout_fail(input string name);
      total_cnt++;
      $display("FAIL %s: timed out waiting (actual=0 required=1) at %0t", name, $time);
   endtask

   // Reference model: a command is either absent, in its single issue cycle
   // (age 0) or waiting as a response (age 1). Expected response payloads
   // {div_zero, zero, carry, result} queue up at acceptance.
   logic [10:0] exp_q[$];
   logic        busy_m, dz_m;
   int          age_m;
   logic [10:0] vis_m;
   logic [15:0] cnt_m;
   logic [3:0]  op_m;
   logic [7:0]  a_m, b_m, acc_m;

   function automatic logic [10:0] expect_rsp(input logic [3:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
      logic [8:0] r;
      logic       dz;
      logic [7:0] res;
      logic       cy;
      dz  = ((op == 4'h6) || (op == 4'h7)) && (b == 8'h00);
      r   = alu_fn(op, a, b);
      res = dz ? 8'hFF : r[7:0];
      cy  = dz ? 1'b0 : r[8];
      return {dz, (res == 8'h00), cy, res};
   endfunction

   always @(negedge Clock_In) begin
      logic [7:0]  a_eff;
      logic [10:0] e;
      if (Reset_In) begin
         busy_m = 1'b0; age_m = 0; dz_m = 1'b0; vis_m = '0; cnt_m = '0;
         op_m = '0; a_m = '0; b_m = '0; acc_m = '0;
         exp_q.delete();
      end
      check("cmd_ready",  32'(Cmd_Ready_Out),  32'(!busy_m));
      check("busy",       32'(Busy_Out),       32'(busy_m));
      check("alu_enable", 32'(ALU_Enable_Out), 32'(busy_m && age_m == 0 && !dz_m));
      check("rsp_valid",  32'(Rsp_Valid_Out),  32'(busy_m && age_m == 1));
      check("alu_op",     32'(ALU_Op_Out),     32'(op_m));
      check("alu_a",      32'(ALU_A_Out),      32'(a_m));
      check("alu_b",      32'(ALU_B_Out),      32'(b_m));
      check("rsp_payload", 32'({Rsp_Div_Zero_Out, Rsp_Zero_Out, Rsp_Carry_Out, Rsp_Result_Out}),
            32'(vis_m));
      check("op_count",   32'(Op_Count_Out),   32'(cnt_m));
      // Advance with the inputs the DUT will see at the next rising edge.
      if (!Reset_In) begin
         if (!busy_m) begin
            if (Cmd_Valid_In) begin
               a_eff = Cmd_A_In;
`ifdef ALU_SEQ_ACCUM_EN
               if (Cmd_Use_Acc_In) a_eff = acc_m;
`endif
               op_m = Cmd_Op_In; a_m = a_eff; b_m = Cmd_B_In;
               e = expect_rsp(op_m, a_m, b_m);
               dz_m = e[10];
               exp_q.push_back(e);
               busy_m = 1'b1; age_m = 0;
            end
         end else if (age_m == 0) begin
            if (exp_q.size() > 0) vis_m = exp_q.pop_front();
`ifdef ALU_SEQ_ACCUM_EN
            acc_m = vis_m[7:0];
`endif
            age_m = 1;
         end else if (Rsp_Ready_In) begin
            cnt_m  = cnt_m + 16'd1;
            busy_m = 1'b0;
         end
      end
   end

   // ---------------- driver tasks (all start/end at posedge + 1) ----------------
   task automatic step();
      @(posedge Clock_In); #1;
   endtask

   task automatic send_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic ua);
      int n = 0;
      while (!Cmd_Ready_Out && n < 20) begin step(); n++; end
      if (!Cmd_Ready_Out) timeout_fail("cmd_ready_wait");
      Cmd_Valid_In = 1'b1; Cmd_Op_In = op; Cmd_A_In = a; Cmd_B_In = b; Cmd_Use_Acc_In = ua;
      step();
      Cmd_Valid_In = 1'b0;
   endtask

   // Waits for the response, stalls 'hold' cycles while throwing stray
   // commands at the busy block, then completes the handshake.
   task automatic get_rsp(input int hold);
      int n = 0;
      while (!Rsp_Valid_Out && n < 20) begin step(); n++; end
      if (!Rsp_Valid_Out) timeout_fail("rsp_valid_wait");
      for (int i = 0; i < hold; i++) begin
         Cmd_Valid_In = 1'($urandom_range(0, 1));
         Cmd_Op_In = 4'($urandom); Cmd_A_In = 8'($urandom); Cmd_B_In = 8'($urandom);
         step();
      end
      Cmd_Valid_In = 1'b0;
      Rsp_Ready_In = 1'b1;
      step();
      Rsp_Ready_In = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] op;
      logic [7:0] b;
      Reset_In = 1'b1;
      Cmd_Valid_In = 1'b0; Cmd_Op_In = '0; Cmd_A_In = '0; Cmd_B_In = '0;
      Cmd_Use_Acc_In = 1'b0; Rsp_Ready_In = 1'b0;
      repeat (2) step();
      check("reset_ready",  32'(Cmd_Ready_Out), 32'd1);
      check("reset_count",  32'(Op_Count_Out),  32'd0);
      Reset_In = 1'b0;
      step();

      // ADD with carry out; response one cycle after the issue cycle
      send_cmd(4'h2, 8'hF0, 8'h20, 1'b0);
      check("add_issue_valid", 32'(Rsp_Valid_Out), 32'd0);
      check("add_issue_en",    32'(ALU_Enable_Out), 32'd1);
      step();
      check("add_valid",  32'(Rsp_Valid_Out),  32'd1);
      check("add_result", 32'(Rsp_Result_Out), 32'h10);
      check("add_carry",  32'(Rsp_Carry_Out),  32'd1);
      check("add_zero",   32'(Rsp_Zero_Out),   32'd0);
      get_rsp(0);
      check("add_count",  32'(Op_Count_Out),   32'd1);
      check("add_retain", 32'(Rsp_Result_Out), 32'h10);

      // SUB to zero
      send_cmd(4'h3, 8'h05, 8'h05, 1'b0);
      step();
      check("sub_result", 32'(Rsp_Result_Out), 32'h00);
      check("sub_zero",   32'(Rsp_Zero_Out),   32'd1);
      check("sub_carry",  32'(Rsp_Carry_Out),  32'd0);
      get_rsp(1);

      // Divide by zero, then a legal modulo
      send_cmd(4'h6, 8'h10, 8'h00, 1'b0);
      check("div0_en", 32'(ALU_Enable_Out), 32'd0);
      step();
      check("div0_result", 32'(Rsp_Result_Out),   32'hFF);
      check("div0_flag",   32'(Rsp_Div_Zero_Out), 32'd1);
      get_rsp(0);
      send_cmd(4'h7, 8'h07, 8'h03, 1'b0);
      step();
      check("mod_result", 32'(Rsp_Result_Out),   32'h01);
      check("mod_flag",   32'(Rsp_Div_Zero_Out), 32'd0);
      get_rsp(0);

      // Back-pressure with a stray command that must be dropped
      send_cmd(4'h2, 8'h11, 8'h22, 1'b0);
      step();
      Cmd_Valid_In = 1'b1; Cmd_Op_In = 4'h5; Cmd_A_In = 8'hAA; Cmd_B_In = 8'hBB;
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_result", 32'(Rsp_Result_Out), 32'h33);
         check("hold_ready",  32'(Cmd_Ready_Out),  32'd0);
         check("hold_alu_a",  32'(ALU_A_Out),      32'h11);
      end
      Cmd_Valid_In = 1'b0; Rsp_Ready_In = 1'b1;
      step();
      Rsp_Ready_In = 1'b0;
      check("hold_count", 32'(Op_Count_Out), 32'd5);
      repeat (3) step();
      check("hold_count_after", 32'(Op_Count_Out), 32'd5);
      check("hold_not_queued",  32'(Busy_Out),     32'd0);

      // Reset in the issue cycle
      send_cmd(4'h2, 8'h01, 8'h02, 1'b0);
      Reset_In = 1'b1;
      #1;
      check("rst_en",    32'(ALU_Enable_Out), 32'd0);
      check("rst_valid", 32'(Rsp_Valid_Out),  32'd0);
      check("rst_count", 32'(Op_Count_Out),   32'd0);
      step();
      Reset_In = 1'b0;
      step();
      send_cmd(4'h8, 8'hF0, 8'h3C, 1'b0);
      step();
      check("and_result", 32'(Rsp_Result_Out), 32'h30);
      get_rsp(2);
      check("and_count", 32'(Op_Count_Out), 32'd1);

`ifdef ALU_SEQ_ACCUM_EN
      send_cmd(4'h0, 8'hFE, 8'h00, 1'b0);
      step();
      check("acc_inc1", 32'(Rsp_Result_Out), 32'hFF);
      get_rsp(0);
      send_cmd(4'h0, 8'h55, 8'h00, 1'b1);
      step();
      check("acc_inc2_result", 32'(Rsp_Result_Out), 32'h00);
      check("acc_inc2_carry",  32'(Rsp_Carry_Out),  32'd1);
      check("acc_inc2_zero",   32'(Rsp_Zero_Out),   32'd1);
      get_rsp(0);
`endif

      // Random traffic against the model
      for (int i = 0; i < 80; i++) begin
         op = 4'($urandom);
         b  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         repeat ($urandom_range(0, 2)) step();
         send_cmd(op, 8'($urandom), b, 1'($urandom_range(0, 1)));
         get_rsp(int'($urandom_range(0, 3)));
      end
      repeat (3) step();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/alu_8_bit_sequencer.md
Name: alu_8_bit_sequencer

Overview:
Registered command front-end for the 8-bit combinational ALU; the ALU instance sits directly downstream of this block.
- Accepts one operation per valid/ready handshake and latches the operands.
- Drives the ALU enable, opcode and data lines for exactly one cycle, then captures the ALU result and carry.
- Returns the captured result with carry, zero and divide-by-zero flags over a second valid/ready handshake.
- Guards divide/modulo by zero, which the ALU does not handle.

Parameters:
COUNT_WIDTH, 16, width of the completed-operation counter.
DIV_ZERO_RESULT, 8'hFF, result returned for opcode 4'h6/4'h7 when B == 0.

Ports:
Clock_In  in  1  single clock; all state changes on its rising edge.
Reset_In  in  1  asynchronous, active-high reset.
Cmd_Valid_In  in  1  command present.
Cmd_Ready_Out  out  1  block can accept a command (high only in IDLE).
Cmd_Op_In  in  4  ALU opcode: 0..7 arithmetic, 8..F logical.
Cmd_A_In  in  8  operand A.
Cmd_B_In  in  8  operand B.
ALU_Enable_Out  out  1  to ALU Enable_In.
ALU_Op_Out  out  4  to ALU operation select.
ALU_A_Out  out  8  to ALU Data_A_In.
ALU_B_Out  out  8  to ALU Data_B_In.
ALU_Result_In  in  8  from ALU Result_Out.
ALU_Carry_In  in  1  from ALU Carry_Out.
Rsp_Valid_Out  out  1  response present.
Rsp_Ready_In  in  1  consumer accepts the response.
Rsp_Result_Out  out  8  captured result.
Rsp_Carry_Out  out  1  captured carry.
Rsp_Zero_Out  out  1  captured result == 8'h00.
Rsp_Div_Zero_Out  out  1  divide/modulo-by-zero flag.
Busy_Out  out  1  state != IDLE.
Op_Count_Out  out  COUNT_WIDTH  number of completed responses.

Behaviour:
- Clock and reset are fixed: one clock, Clock_In; Reset_In is asynchronous and active-high.
- Reset: state = IDLE, every register and every output = 0 except Cmd_Ready_Out = 1.
  - Reset mid-operation discards the pending command and response.
  - ALU_Enable_Out drops immediately, without waiting for a clock edge.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - Cmd_Ready_Out = 1.
  - On Cmd_Valid_In & Cmd_Ready_Out at an edge: latch op/A/B into ALU_Op_Out/ALU_A_Out/ALU_B_Out, go to ISSUE.
- ISSUE, exactly one cycle:
  - ALU_Enable_Out = 1, unless the op is 4'h6 or 4'h7 with B == 0.
  - At the closing edge, capture ALU_Result_In and ALU_Carry_In.
  - On divide/modulo by zero, capture DIV_ZERO_RESULT, carry 0, Rsp_Div_Zero_Out = 1 instead.
  - Zero flag is computed from the captured result. Go to RESP.
- RESP:
  - Rsp_Valid_Out = 1; all Rsp_* outputs held stable until Rsp_Ready_In is sampled high.
  - On that edge: Op_Count_Out += 1 (wraps modulo 2^COUNT_WIDTH), go to IDLE.
- Latency and throughput:
  - Command accepted at edge k gives Rsp_Valid_Out high after edge k+1.
  - Minimum of 3 cycles per command; no overlap.
  - Cmd_Valid_In outside IDLE is ignored and not queued.
- ALU lines:
  - ALU_Enable_Out = 0 outside ISSUE, so the ALU outputs are Z then and must not be sampled.
  - ALU_Op/A/B_Out hold their last latched values.
- Rsp_* outputs retain their last values after the handshake; only Rsp_Valid_Out drops.
- Arithmetic is the ALU's 9-bit result split into Rsp_Result_Out and Rsp_Carry_Out. The sequencer adds no arithmetic of its own.

Optional Feature:
ALU_SEQ_ACCUM_EN
- Defined:
  - Adds input port Cmd_Use_Acc_In (1 bit) and an 8-bit accumulator register, reset to 0.
  - The accumulator loads the captured result at the end of every ISSUE.
  - If Cmd_Use_Acc_In = 1 at acceptance, the accumulator value replaces Cmd_A_In as operand A.
  - The divide-by-zero check uses the substituted operands.
- Undefined: no port, no accumulator; operand A always comes from Cmd_A_In.

Decomposition:
- Package alu_seq_pkg contains:
  - Opcode constants OP_INC, OP_DEC, OP_ADD, OP_SUB, OP_RSUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_NOTA, OP_NOTB, OP_NAND, OP_NOR, OP_XOR, OP_XNOR.
  - The state encoding IDLE/ISSUE/RESP.
- No sub-module. The ALU is instantiated beside this block in the parent and connected through the ALU_* ports.

Test Plan:
- Reset, then op=2 A=8'hF0 B=8'h20 -> Rsp_Valid_Out after 2 edges; result 8'h10, carry 1, zero 0, Op_Count_Out = 1.
- op=3 A=8'h05 B=8'h05 -> result 8'h00, zero 1, carry 0.
- op=6 A=8'h10 B=8'h00 -> ALU_Enable_Out never asserts; result 8'hFF, div_zero 1. Then op=7 A=8'h07 B=8'h03 -> result 8'h01, div_zero 0.
- Hold Rsp_Ready_In low for 5 cycles while Cmd_Valid_In is high with new data -> Rsp_* stable, Cmd_Ready_Out = 0, extra command dropped, Op_Count_Out increments exactly once.
- Assert Reset_In during ISSUE -> ALU_Enable_Out, Rsp_Valid_Out and Op_Count_Out = 0 immediately; next command op=8 A=8'hF0 B=8'h3C -> result 8'h30.
- With ALU_SEQ_ACCUM_EN: op=0 A=8'hFE -> 8'hFF; then op=0 with Cmd_Use_Acc_In=1 -> result 8'h00, carry 1, zero 1.
